// File: rtl/rsa_pkg.sv
// Shared constants for the RSA modular-exponentiation sequencer: core register
// selects, FSM state codes and the default operand size.
package rsa_pkg;

  localparam int NBYTES_DEF = 32;

  // Core register-file selects
  localparam logic [1:0] SEL_RES = 2'd0;
  localparam logic [1:0] SEL_M   = 2'd1;
  localparam logic [1:0] SEL_E   = 2'd2;
  localparam logic [1:0] SEL_N   = 2'd3;

  // Sequencer states
  typedef logic [3:0] state_t;
  localparam state_t ST_CRST      = 4'd0;
  localparam state_t ST_LOAD_N    = 4'd1;
  localparam state_t ST_LOAD_M    = 4'd2;
  localparam state_t ST_LOAD_E    = 4'd3;
  localparam state_t ST_START     = 4'd4;
  localparam state_t ST_WAIT_DONE = 4'd5;
  localparam state_t ST_RD_REQ    = 4'd6;
  localparam state_t ST_RD_CAP    = 4'd7;
  localparam state_t ST_SEND      = 4'd8;

  // Register select used while a given load state is active
  function automatic logic [1:0] load_sel(input state_t s);
    case (s)
      ST_LOAD_N: load_sel = SEL_N;
      ST_LOAD_M: load_sel = SEL_M;
      ST_LOAD_E: load_sel = SEL_E;
      default:   load_sel = SEL_RES;
    endcase
  endfunction

endpackage

// File: rtl/rsa_seq_ctrl.sv
// Sequencer for the 256-bit RSA modexp core: loads N, M, E from the host byte
// stream, starts the core, waits for completion and streams the result back.
//
// Handshakes: a byte moves on in_valid/in_ready (or out_valid/out_ready) only in
// a cycle where both are high at the rising clock edge; the producer holds data
// stable while valid is high and ready is low; ready never depends on valid.
module rsa_seq_ctrl
  import rsa_pkg::*;
#(
  parameter int NBYTES     = NBYTES_DEF,
  parameter int BUSY_WAIT  = 16,
  parameter int RST_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       core_rst,
  output logic       core_we_n,
  output logic       core_oe_n,
  output logic [1:0] core_reg_sel,
  output logic [5:0] core_addr,
  output logic [7:0] core_wdata,
  input  logic [7:0] core_rdata,
  output logic       core_start,
  input  logic       core_busy,
  output logic       busy,
  output logic       err,
  output logic [3:0] dbg_state
);

  localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);
  localparam logic [7:0] TMO_LAST = 8'(BUSY_WAIT - 1);
  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] tmo_q, tmo_d;
  logic [3:0] rst_cnt_q, rst_cnt_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       core_rst_q, core_rst_d;
  logic       we_n_q, we_n_d;
  logic       oe_n_q, oe_n_d;
  logic [1:0] reg_sel_q, reg_sel_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       in_hs;

  assign in_hs = in_valid && in_ready_q;

  // Next-state and next-output logic; strobes default inactive so each lasts one cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    rst_cnt_d   = rst_cnt_q;
    in_ready_d  = in_ready_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    core_rst_d  = core_rst_q;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    reg_sel_d   = reg_sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    start_d     = start_q;
    err_d       = err_q;

    case (state_q)
      ST_CRST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d    = ST_LOAD_N;
          core_rst_d = 1'b0;
          in_ready_d = 1'b1;
          rst_cnt_d  = 4'd0;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end
      ST_LOAD_N, ST_LOAD_M, ST_LOAD_E: begin
        if (in_hs) begin
          we_n_d    = 1'b0;
          reg_sel_d = load_sel(state_q);
          addr_d    = idx_q;
          wdata_d   = in_data;
          // The first accepted byte marks the start of a new job
          if (state_q == ST_LOAD_N && idx_q == 6'd0) err_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d = 6'd0;
            case (state_q)
              ST_LOAD_N: state_d = ST_LOAD_M;
              ST_LOAD_M: state_d = ST_LOAD_E;
              default: begin
                state_d    = ST_START;
                in_ready_d = 1'b0;
              end
            endcase
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_START: begin
        start_d = 1'b1;
        if (start_q) begin
          if (core_busy) begin
            start_d = 1'b0;
            tmo_d   = 8'd0;
            state_d = ST_WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            start_d    = 1'b0;
            err_d      = 1'b1;
            tmo_d      = 8'd0;
            core_rst_d = 1'b1;
            rst_cnt_d  = 4'd0;
            state_d    = ST_CRST;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!core_busy) begin
          oe_n_d    = 1'b0;
          reg_sel_d = SEL_RES;
          addr_d    = idx_q;
          state_d   = ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        out_data_d  = core_rdata;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 6'd1;
            oe_n_d    = 1'b0;
            reg_sel_d = SEL_RES;
            addr_d    = idx_q + 6'd1;
            state_d   = ST_RD_REQ;
          end else begin
            idx_d      = 6'd0;
            core_rst_d = 1'b1;
            rst_cnt_d  = 4'd0;
            state_d    = ST_CRST;
          end
        end
      end
      default: begin
        core_rst_d = 1'b1;
        rst_cnt_d  = 4'd0;
        state_d    = ST_CRST;
      end
    endcase

    busy_d = !(state_d == ST_LOAD_N && idx_d == 6'd0);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CRST;
      idx_q       <= 6'd0;
      tmo_q       <= 8'd0;
      rst_cnt_q   <= 4'd0;
      in_ready_q  <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      core_rst_q  <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      reg_sel_q   <= SEL_RES;
      addr_q      <= 6'd0;
      wdata_q     <= 8'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      rst_cnt_q   <= rst_cnt_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      core_rst_q  <= core_rst_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      reg_sel_q   <= reg_sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign core_rst     = core_rst_q;
  assign core_we_n    = we_n_q;
  assign core_oe_n    = oe_n_q;
  assign core_reg_sel = reg_sel_q;
  assign core_addr    = addr_q;
  assign core_wdata   = wdata_q;
  assign core_start   = start_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule
